mode_record: RTL and testbench

// - Record mode: the counterpart of auto-play. Captures notes played live on the keys
//   (note code, octave, duration) into a slot buffer.
// - Buffer uses the packed song/time/octave format the auto-play path consumes, so a

---
 rtl/mode_record.sv | 175 +++++++++++++++++
 tb/tb_mode_record.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_record.sv
// Live-key recorder: captures note/octave/duration entries into the packed slot
// format used by the auto-play path, ending each take with a terminator slot.
module mode_record #(
    parameter int TICK_CYCLES = 10000000,
    parameter int SLOTS       = 56,
    parameter int LEN_W       = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rec_start,
    input  logic                 rec_stop,
    input  logic [3:0]           note_in,
    input  logic [1:0]           octave_in,
    output logic [SLOTS*4-1:0]   song_packed,
    output logic [SLOTS*4-1:0]   time_packed,
    output logic [SLOTS*2-1:0]   octave_packed,
    output logic [LEN_W-1:0]     rec_len,
    output logic                 recording,
    output logic                 full,
    output logic [6:0]           led_out
);
    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [LEN_W-1:0]  LEN_LAST  = LEN_W'(SLOTS - 1);

    typedef enum logic [1:0] {S_IDLE, S_REC, S_FINISH} state_t;

    state_t             r_state;
    logic               r_prev_start;
    logic               r_prev_stop;
    logic [TICK_W-1:0]  r_tick;
    logic [3:0]         r_unit;
    logic [3:0]         r_cur_note;
    logic [1:0]         r_cur_oct;
    logic [LEN_W-1:0]   r_len;
    logic               r_recording;
    logic               r_full;
    logic [6:0]         r_led;

    logic               w_start_edge;
    logic               w_stop_edge;
    logic               w_note_change;
    logic               w_wrap;
    logic               w_commit;
    logic [3:0]         w_dur;
    logic               w_write;
    logic               w_cap;
    logic               w_clear;
    logic               w_term;
    logic [IDX_W-1:0]   w_idx;

    assign w_start_edge  = rec_start & ~r_prev_start;
    assign w_stop_edge   = rec_stop & ~r_prev_stop;
    assign w_note_change = (note_in != r_cur_note) || (octave_in != r_cur_oct);
    assign w_wrap        = (r_tick == TICK_LAST);
    assign w_idx         = r_len[IDX_W-1:0];
    assign w_clear       = (r_state == S_IDLE) && w_start_edge;
    assign w_term        = (r_state == S_FINISH);

    // Stop beats a note change, which beats the 15-unit saturation split.
    always_comb begin
        w_commit = 1'b0;
        w_dur    = r_unit;
        if (r_state == S_REC) begin
            if (w_stop_edge || w_note_change) begin
                w_commit = 1'b1;
            end else if (w_wrap && (r_unit == 4'd14)) begin
                w_commit = 1'b1;
                w_dur    = 4'd15;
            end
        end
    end

    // Sub-unit entries are treated as key glitches and never reach the buffer.
    assign w_write = w_commit && (w_dur != 4'd0);
    assign w_cap   = w_write && ((r_len + LEN_W'(1)) == LEN_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_prev_start <= 1'b0;
            r_prev_stop  <= 1'b0;
            r_tick       <= '0;
            r_unit       <= 4'd0;
            r_cur_note   <= 4'd0;
            r_cur_oct    <= 2'd0;
            r_len        <= '0;
            r_recording  <= 1'b0;
            r_full       <= 1'b0;
            r_led        <= 7'd0;
        end else begin
            r_prev_start <= rec_start;
            r_prev_stop  <= rec_stop;
            r_led        <= 7'd0;
            if ((r_state == S_REC) && (note_in >= 4'd1) && (note_in <= 4'd7)) begin
                r_led <= 7'd1 << (note_in - 4'd1);
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_len       <= '0;
                        r_full      <= 1'b0;
                        r_tick      <= '0;
                        r_unit      <= 4'd0;
                        r_cur_note  <= note_in;
                        r_cur_oct   <= octave_in;
                        r_recording <= 1'b1;
                        r_state     <= S_REC;
                    end
                end
                S_REC: begin
                    if (w_write) begin
                        r_len <= r_len + LEN_W'(1);
                    end
                    if (w_stop_edge || w_cap) begin
                        r_recording <= 1'b0;
                        r_state     <= S_FINISH;
                        if (w_cap) begin
                            r_full <= 1'b1;
                        end
                    end else if (w_note_change) begin
                        r_cur_note <= note_in;
                        r_cur_oct  <= octave_in;
                        r_tick     <= '0;
                        r_unit     <= 4'd0;
                    end else if (w_wrap) begin
                        r_tick <= '0;
                        r_unit <= (r_unit == 4'd14) ? 4'd0 : r_unit + 4'd1;
                    end else begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end
                S_FINISH: begin
                    r_recording <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
        logic [3:0] r_song_s;
        logic [3:0] r_time_s;
        logic [1:0] r_oct_s;

        always_ff @(posedge clk) begin
            if (!reset || w_clear) begin
                r_song_s <= 4'd0;
                r_time_s <= 4'd0;
                r_oct_s  <= 2'd0;
            end else if (w_write && (w_idx == IDX_W'(gi))) begin
                r_song_s <= r_cur_note;
                r_time_s <= w_dur;
                r_oct_s  <= r_cur_oct;
            end else if (w_term && (w_idx == IDX_W'(gi))) begin
                r_song_s <= 4'hF;
                r_time_s <= 4'd0;
                r_oct_s  <= 2'd0;
            end
        end

        assign song_packed[4*gi +: 4]   = r_song_s;
        assign time_packed[4*gi +: 4]   = r_time_s;
        assign octave_packed[2*gi +: 2] = r_oct_s;
    end

    assign rec_len   = r_len;
    assign recording = r_recording;
    assign full      = r_full;
    assign led_out   = r_led;
endmodule

// File: tb/tb_mode_record.sv
// Bench for mode_record: small-buffer instance checked against a duration-count
// model under random play, plus a 56-slot instance driven from a scenario table.
module tb_mode_record;
    localparam int T  = 4;
    localparam int SA = 4;
    localparam int SB = 56;
    localparam int LW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic            a_start, a_stop;
    logic [3:0]      a_note;
    logic [1:0]      a_oct;
    logic [SA*4-1:0] a_song, a_time;
    logic [SA*2-1:0] a_octp;
    logic [LW-1:0]   a_len;
    logic            a_rec, a_full;
    logic [6:0]      a_led;

    logic            b_start, b_stop;
    logic [3:0]      b_note;
    logic [1:0]      b_oct;
    logic [SB*4-1:0] b_song, b_time;
    logic [SB*2-1:0] b_octp;
    logic [LW-1:0]   b_len;
    logic            b_rec, b_full;
    logic [6:0]      b_led;

    mode_record #(.TICK_CYCLES(T), .SLOTS(SA), .LEN_W(LW)) dut_a (
        .clk(clk), .reset(reset), .rec_start(a_start), .rec_stop(a_stop),
        .note_in(a_note), .octave_in(a_oct), .song_packed(a_song),
        .time_packed(a_time), .octave_packed(a_octp), .rec_len(a_len),
        .recording(a_rec), .full(a_full), .led_out(a_led)
    );

    mode_record #(.TICK_CYCLES(T), .SLOTS(SB), .LEN_W(LW)) dut_b (
        .clk(clk), .reset(reset), .rec_start(b_start), .rec_stop(b_stop),
        .note_in(b_note), .octave_in(b_oct), .song_packed(b_song),
        .time_packed(b_time), .octave_packed(b_octp), .rec_len(b_len),
        .recording(b_rec), .full(b_full), .led_out(b_led)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model for instance A: a take is a list of entries; the running
    // entry's length is a plain count of elapsed cycles, divided by T on commit.
    int         m_len;
    logic [3:0] m_song [SA];
    logic [3:0] m_time [SA];
    logic [1:0] m_octs [SA];
    bit         m_rec, m_term, m_full;
    int         m_n;
    logic [3:0] m_note;
    logic [1:0] m_o;
    logic       m_ps, m_pst;
    logic [6:0] m_led;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < SA; i++) begin
            m_song[i] = 4'd0;
            m_time[i] = 4'd0;
            m_octs[i] = 2'd0;
        end
        m_len  = 0;
        m_full = 1'b0;
    endtask

    task automatic model_commit(input int dur, output bit wrote);
        wrote = 1'b0;
        if (dur > 0) begin
            m_song[m_len] = m_note;
            m_time[m_len] = 4'(dur);
            m_octs[m_len] = m_o;
            m_len++;
            wrote = 1'b1;
        end
    endtask

    task automatic model_step();
        bit se, pe, wrote, fin;
        if (!reset) begin
            model_clear();
            m_rec = 1'b0; m_term = 1'b0; m_n = 0;
            m_ps = 1'b0; m_pst = 1'b0; m_led = 7'd0;
        end else begin
            se = a_start && !m_ps;
            pe = a_stop && !m_pst;
            m_led = 7'd0;
            if (m_rec && a_note >= 4'd1 && a_note <= 4'd7) m_led = 7'd1 << (a_note - 4'd1);
            if (m_term) begin
                m_song[m_len] = 4'hF;
                m_time[m_len] = 4'd0;
                m_octs[m_len] = 2'd0;
                m_term = 1'b0;
            end else if (m_rec) begin
                wrote = 1'b0;
                fin   = pe;
                if (pe) begin
                    model_commit(m_n / T, wrote);
                end else if (a_note != m_note || a_oct != m_o) begin
                    model_commit(m_n / T, wrote);
                    m_note = a_note;
                    m_o    = a_oct;
                    m_n    = 0;
                end else begin
                    m_n++;
                    if (m_n == 15 * T) begin
                        model_commit(15, wrote);
                        m_n = 0;
                    end
                end
                if (wrote && m_len == SA - 1) begin
                    m_full = 1'b1;
                    fin    = 1'b1;
                end
                if (fin) begin
                    m_rec  = 1'b0;
                    m_term = 1'b1;
                end
            end else if (se) begin
                model_clear();
                m_n    = 0;
                m_note = a_note;
                m_o    = a_oct;
                m_rec  = 1'b1;
            end
            m_ps  = a_start;
            m_pst = a_stop;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag);
        logic [SA*4-1:0] es, et;
        logic [SA*2-1:0] eo;
        for (int i = 0; i < SA; i++) begin
            es[4*i +: 4] = m_song[i];
            et[4*i +: 4] = m_time[i];
            eo[2*i +: 2] = m_octs[i];
        end
        chk({tag, ".song"}, 64'(a_song), 64'(es));
        chk({tag, ".time"}, 64'(a_time), 64'(et));
        chk({tag, ".oct"},  64'(a_octp), 64'(eo));
        chk({tag, ".len"},  64'(a_len),  64'(m_len));
        chk({tag, ".rec"},  64'(a_rec),  64'(m_rec));
        chk({tag, ".full"}, 64'(a_full), 64'(m_full));
        chk({tag, ".led"},  64'(a_led),  64'(m_led));
    endtask

    // Directed take: per-segment note/octave/hold and the resulting first four slots.
    typedef struct packed {
        logic [2:0]      nseg;
        logic [3:0][3:0] note;
        logic [3:0][1:0] oct;
        logic [3:0][7:0] hold;
        logic [3:0]      exp_len;
        logic [15:0]     exp_song;
        logic [15:0]     exp_time;
        logic [7:0]      exp_oct;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0].nseg = 3'd2; vecs[0].note = {4'd0, 4'd0, 4'd5, 4'd3};
        vecs[0].oct  = {2'd0, 2'd0, 2'd1, 2'd1}; vecs[0].hold = {8'd0, 8'd0, 8'd8, 8'd10};
        vecs[0].exp_len = 4'd2; vecs[0].exp_song = 16'h0F53;
        vecs[0].exp_time = 16'h0022; vecs[0].exp_oct = 8'h05;

        vecs[1].nseg = 3'd3; vecs[1].note = {4'd0, 4'd1, 4'd2, 4'd1};
        vecs[1].oct  = {2'd0, 2'd2, 2'd2, 2'd2}; vecs[1].hold = {8'd0, 8'd4, 8'd3, 8'd8};
        vecs[1].exp_len = 4'd2; vecs[1].exp_song = 16'h0F11;
        vecs[1].exp_time = 16'h0012; vecs[1].exp_oct = 8'h0A;

        vecs[2].nseg = 3'd1; vecs[2].note = {4'd0, 4'd0, 4'd0, 4'd6};
        vecs[2].oct  = {2'd0, 2'd0, 2'd0, 2'd3}; vecs[2].hold = {8'd0, 8'd0, 8'd0, 8'd64};
        vecs[2].exp_len = 4'd2; vecs[2].exp_song = 16'h0F66;
        vecs[2].exp_time = 16'h001F; vecs[2].exp_oct = 8'h0F;

        vecs[3].nseg = 3'd2; vecs[3].note = {4'd0, 4'd0, 4'd7, 4'd0};
        vecs[3].oct  = {2'd0, 2'd0, 2'd1, 2'd0}; vecs[3].hold = {8'd0, 8'd0, 8'd12, 8'd5};
        vecs[3].exp_len = 4'd2; vecs[3].exp_song = 16'h0F70;
        vecs[3].exp_time = 16'h0031; vecs[3].exp_oct = 8'h04;

        reset = 1'b0;
        a_start = 1'b0; a_stop = 1'b0; a_note = 4'd0; a_oct = 2'd0;
        b_start = 1'b0; b_stop = 1'b0; b_note = 4'd0; b_oct = 2'd0;

        // Reset held three cycles, then a stop edge while idle.
        repeat (3) cycle();
        chk("rst.song", 64'(a_song), 64'd0);
        chk("rst.len",  64'(a_len),  64'd0);
        chk("rst.rec",  64'(a_rec),  64'd0);
        chk("rst.full", 64'(a_full), 64'd0);
        chk("rst.led",  64'(a_led),  64'd0);
        reset = 1'b1;
        a_stop = 1'b1; cycle();
        a_stop = 1'b0; cycle();
        chk("idle_stop.rec",  64'(a_rec),  64'd0);
        chk("idle_stop.song", 64'(a_song), 64'd0);
        check_a("idle_stop");
        $display("txn reset/idle-stop: rec=%0d len=%0d", a_rec, a_len);

        // Capacity: fourth note must never land; third commit fills the buffer.
        a_note = 4'd1; a_oct = 2'd0; a_start = 1'b1; cycle();
        a_start = 1'b0;
        repeat (4) cycle();
        a_note = 4'd2; cycle();
        chk("cap.led", 64'(a_led), 64'h02);
        repeat (4) cycle();
        a_note = 4'd3; cycle();
        repeat (4) cycle();
        chk("cap.rec_before", 64'(a_rec), 64'd1);
        a_note = 4'd4; cycle();
        chk("cap.full", 64'(a_full), 64'd1);
        chk("cap.rec_after", 64'(a_rec), 64'd0);
        chk("cap.len", 64'(a_len), 64'd3);
        cycle();
        chk("cap.song", 64'(a_song), 64'hF321);
        chk("cap.time", 64'(a_time), 64'h0111);
        repeat (4) cycle();
        a_note = 4'd5; cycle();
        chk("cap.len_hold", 64'(a_len), 64'd3);
        chk("cap.song_hold", 64'(a_song), 64'hF321);
        check_a("cap");
        $display("txn capacity: len=%0d full=%0d song=%h", a_len, a_full, a_song);

        // Reset mid-take, then a fresh take.
        a_note = 4'd2; a_oct = 2'd1; a_start = 1'b1; cycle();
        a_start = 1'b0;
        repeat (4) cycle();
        a_note = 4'd3; cycle();
        repeat (4) cycle();
        a_note = 4'd4; cycle();
        chk("midrst.len_pre", 64'(a_len), 64'd2);
        reset = 1'b0; cycle();
        reset = 1'b1;
        chk("midrst.song", 64'(a_song), 64'd0);
        chk("midrst.time", 64'(a_time), 64'd0);
        chk("midrst.oct",  64'(a_octp), 64'd0);
        chk("midrst.len",  64'(a_len),  64'd0);
        chk("midrst.rec",  64'(a_rec),  64'd0);
        a_note = 4'd6; a_oct = 2'd2; a_start = 1'b1; cycle();
        a_start = 1'b0;
        repeat (8) cycle();
        a_stop = 1'b1; cycle(); cycle();
        a_stop = 1'b0;
        chk("retake.len",  64'(a_len),  64'd1);
        chk("retake.song", 64'(a_song), 64'h00F6);
        chk("retake.time", 64'(a_time), 64'h0002);
        chk("retake.oct",  64'(a_octp), 64'h02);
        check_a("retake");
        $display("txn reset-mid-rec: len=%0d song=%h", a_len, a_song);

        // Random play against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) a_note = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 19) == 0) a_oct = 2'($urandom_range(0, 3));
            a_start = ($urandom_range(0, 30) == 0);
            a_stop  = ($urandom_range(0, 60) == 0);
            reset   = ($urandom_range(0, 400) != 0);
            cycle();
            check_a("rnd");
        end
        reset = 1'b1; a_start = 1'b0; a_stop = 1'b0;
        cycle();
        $display("txn random: %0d checks so far", n_checks);

        // Scenario table on the 56-slot instance.
        for (int r = 0; r < 4; r++) begin
            b_note = vecs[r].note[0]; b_oct = vecs[r].oct[0]; b_start = 1'b1;
            cycle();
            b_start = 1'b0;
            for (int s = 0; s < int'(vecs[r].nseg); s++) begin
                if (s > 0) begin
                    b_note = vecs[r].note[s]; b_oct = vecs[r].oct[s];
                    cycle();
                end
                repeat (int'(vecs[r].hold[s])) cycle();
            end
            b_stop = 1'b1; cycle(); cycle();
            b_stop = 1'b0; cycle();
            chk($sformatf("row%0d.song", r), 64'(b_song[15:0]), 64'(vecs[r].exp_song));
            chk($sformatf("row%0d.time", r), 64'(b_time[15:0]), 64'(vecs[r].exp_time));
            chk($sformatf("row%0d.oct", r),  64'(b_octp[7:0]),  64'(vecs[r].exp_oct));
            chk($sformatf("row%0d.len", r),  64'(b_len),        64'(vecs[r].exp_len));
            chk($sformatf("row%0d.full", r), 64'(b_full),       64'd0);
            chk($sformatf("row%0d.rec", r),  64'(b_rec),        64'd0);
            $display("txn row %0d: len=%0d song=%h time=%h", r, b_len, b_song[15:0], b_time[15:0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
